// File: rtl/display_pkg.sv
// Shared definitions for the result-display stream: phase tags, error causes,
// collector state encoding and shadow-buffer geometry.
package display_pkg;

  localparam int unsigned PH_W            = 3;
  localparam int unsigned ERR_W           = 3;
  localparam int unsigned ST_W            = 3;
  localparam int unsigned WORDS_PER_PHASE = 4;
  localparam int unsigned NUM_SLOTS       = 12;
  localparam int unsigned CNT_W           = 4;

  localparam logic [PH_W-1:0] PH_IDLE = 3'd0;
  localparam logic [PH_W-1:0] PH_PE   = 3'd1;
  localparam logic [PH_W-1:0] PH_3X3  = 3'd2;
  localparam logic [PH_W-1:0] PH_2X2  = 3'd3;
  localparam logic [PH_W-1:0] PH_DONE = 3'd4;

  localparam logic [ERR_W-1:0] ERR_NONE    = 3'd0;
  localparam logic [ERR_W-1:0] ERR_ORDER   = 3'd1;
  localparam logic [ERR_W-1:0] ERR_EARLY   = 3'd2;
  localparam logic [ERR_W-1:0] ERR_OVERRUN = 3'd3;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 3'd4;
  localparam logic [ERR_W-1:0] ERR_GAP     = 3'd5;

  localparam logic [ST_W-1:0] S_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] S_COLLECT = 3'd1;
  localparam logic [ST_W-1:0] S_CHECK   = 3'd2;
  localparam logic [ST_W-1:0] S_DONE    = 3'd3;
  localparam logic [ST_W-1:0] S_ERR     = 3'd4;

  // Phase tag that must accompany the byte landing in slot cnt.
  function automatic logic [PH_W-1:0] expected_tag(input logic [CNT_W-1:0] cnt);
    return PH_W'(cnt / CNT_W'(WORDS_PER_PHASE)) + PH_W'(1);
  endfunction

endpackage

// File: rtl/display_slot_buffer.sv
// 12-entry shadow storage for incoming result bytes, with its own write index.
module display_slot_buffer
  import display_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_i,
  input  logic                          wr_i,
  input  logic                          clr_i,
  input  logic [DATA_W-1:0]             data_i,
  output logic [CNT_W-1:0]              cnt_o,
  output logic [NUM_SLOTS*DATA_W-1:0]   slots_o
);

  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0][DATA_W-1:0]  slots_q, slots_d;

  // start_i restarts at slot 0; wr_i appends at the current index.
  always_comb begin
    cnt_d   = cnt_q;
    slots_d = slots_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      slots_d[0] = data_i;
      cnt_d      = CNT_W'(1);
    end else if (wr_i && (cnt_q < CNT_W'(NUM_SLOTS))) begin
      slots_d[cnt_q] = data_i;
      cnt_d          = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      slots_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      slots_q <= slots_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign slots_o = slots_q;

endmodule

// File: rtl/display_collector.sv
// Rebuilds PE / 3x3 / 2x2 result matrices from the display byte stream and
// cross-checks PE against the other two before signalling done or error.
module display_collector
  import display_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear_i,
  input  logic [DATA_W-1:0]              display_result_i,
  input  logic [PH_W-1:0]                state_display_i,
  output logic [WORDS_PER_PHASE*DATA_W-1:0] pe_mat_o,
  output logic [WORDS_PER_PHASE*DATA_W-1:0] mat3x3_o,
  output logic [WORDS_PER_PHASE*DATA_W-1:0] mat2x2_o,
  output logic                           match_3x3_o,
  output logic                           match_2x2_o,
  output logic                           done_o,
  output logic                           busy_o,
  output logic                           err_o,
  output logic [ERR_W-1:0]               err_code_o
);

  localparam int unsigned MAT_W = WORDS_PER_PHASE * DATA_W;
  localparam int unsigned WD_W  = $clog2(TIMEOUT);

  logic [ST_W-1:0]  state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [ERR_W-1:0] err_code_q, err_code_d;
  logic [MAT_W-1:0] pe_mat_q, pe_mat_d, mat3x3_q, mat3x3_d, mat2x2_q, mat2x2_d;
  logic             match_3x3_q, match_3x3_d, match_2x2_q, match_2x2_d;
  logic             done_q, done_d, busy_q, busy_d, err_q, err_d;

  logic                             buf_start, buf_wr, buf_clr;
  logic [CNT_W-1:0]                 cnt;
  logic [NUM_SLOTS-1:0][DATA_W-1:0] slots;
  logic [MAT_W-1:0]                 pe_new, m3_new, m2_new;
  logic                             tag_is_data;

  display_slot_buffer #(.DATA_W(DATA_W)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .start_i (buf_start),
    .wr_i    (buf_wr),
    .clr_i   (buf_clr),
    .data_i  (display_result_i),
    .cnt_o   (cnt),
    .slots_o (slots)
  );

  assign pe_new      = {slots[0], slots[1], slots[2],  slots[3]};
  assign m3_new      = {slots[4], slots[5], slots[6],  slots[7]};
  assign m2_new      = {slots[8], slots[9], slots[10], slots[11]};
  assign tag_is_data = (state_display_i >= PH_PE) && (state_display_i <= PH_2X2);

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    err_code_d  = err_code_q;
    pe_mat_d    = pe_mat_q;
    mat3x3_d    = mat3x3_q;
    mat2x2_d    = mat2x2_q;
    match_3x3_d = match_3x3_q;
    match_2x2_d = match_2x2_q;
    buf_start   = 1'b0;
    buf_wr      = 1'b0;
    buf_clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (state_display_i == PH_PE) begin
          buf_start = 1'b1;
          wd_d      = '0;
          state_d   = S_COLLECT;
        end
      end
      // Rule order matters: watchdog, then done/overrun, then data, then gap/order.
      S_COLLECT: begin
        wd_d = wd_q + WD_W'(1);
        if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d    = S_ERR;
          err_code_d = ERR_TIMEOUT;
        end else if (state_display_i == PH_DONE && cnt == CNT_W'(NUM_SLOTS)) begin
          state_d = S_CHECK;
        end else if (state_display_i == PH_DONE) begin
          state_d    = S_ERR;
          err_code_d = ERR_EARLY;
        end else if (tag_is_data && cnt == CNT_W'(NUM_SLOTS)) begin
          state_d    = S_ERR;
          err_code_d = ERR_OVERRUN;
        end else if (state_display_i == expected_tag(cnt)) begin
          buf_wr = 1'b1;
        end else if (state_display_i == PH_IDLE) begin
          state_d    = S_ERR;
          err_code_d = ERR_GAP;
        end else begin
          state_d    = S_ERR;
          err_code_d = ERR_ORDER;
        end
      end
      S_CHECK: begin
        pe_mat_d    = pe_new;
        mat3x3_d    = m3_new;
        mat2x2_d    = m2_new;
        match_3x3_d = (pe_new == m3_new);
        match_2x2_d = (pe_new == m2_new);
        state_d     = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (clear_i) begin
          state_d    = S_IDLE;
          err_code_d = ERR_NONE;
          buf_clr    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_COLLECT) || (state_d == S_CHECK);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wd_q        <= '0;
      err_code_q  <= ERR_NONE;
      pe_mat_q    <= '0;
      mat3x3_q    <= '0;
      mat2x2_q    <= '0;
      match_3x3_q <= 1'b0;
      match_2x2_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      err_code_q  <= err_code_d;
      pe_mat_q    <= pe_mat_d;
      mat3x3_q    <= mat3x3_d;
      mat2x2_q    <= mat2x2_d;
      match_3x3_q <= match_3x3_d;
      match_2x2_q <= match_2x2_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign pe_mat_o    = pe_mat_q;
  assign mat3x3_o    = mat3x3_q;
  assign mat2x2_o    = mat2x2_q;
  assign match_3x3_o = match_3x3_q;
  assign match_2x2_o = match_2x2_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

endmodule
